// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 32-bit MIPS words and writes
// them to consecutive word addresses of instruction memory.
// Optional feature: define INSTR_ENC_BNE_EN to make kind 110 (BNE) legal.
module instr_encoder #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic        mem_ack,
  output logic [15:0] count,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CW = 16;

  localparam logic [2:0] K_RTYPE = 3'b000;
  localparam logic [2:0] K_LW    = 3'b001;
  localparam logic [2:0] K_SW    = 3'b010;
  localparam logic [2:0] K_BEQ   = 3'b011;
  localparam logic [2:0] K_ADDI  = 3'b100;
  localparam logic [2:0] K_J     = 3'b101;
  localparam logic [2:0] K_BNE   = 3'b110;
  localparam logic [2:0] K_END   = 3'b111;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_ILLEGAL = 2'b01;
  localparam logic [1:0] E_OVFL    = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, WRITE, ERR} state_t;

  state_t          state_q, state_d;
  logic            in_ready_d, mem_we_d, done_d, err_d;
  logic [31:0]     mem_addr_d, mem_wd_d;
  logic [CW-1:0]   count_d;
  logic [1:0]      err_code_d;
  logic [31:0]     enc_word;
  logic            enc_legal;

  // Encode the offered instruction; enc_legal marks kinds that produce a word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_kind)
      K_RTYPE: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
      K_ADDI:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      K_J:     enc_word = {6'b000010, in_target};
`ifdef INSTR_ENC_BNE_EN
      K_BNE:   enc_word = {6'b000101, in_rs, in_rt, in_imm};
`else
      K_BNE:   enc_legal = 1'b0;
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic; in_ready/mem_we follow the next state.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr;
    mem_wd_d   = mem_wd;
    count_d    = count;
    err_d      = err;
    err_code_d = err_code;
    done_d     = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          mem_addr_d = base_addr & ~32'd3;
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = E_NONE;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (in_kind == K_END) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (!enc_legal) begin
            err_d      = 1'b1;
            err_code_d = E_ILLEGAL;
            state_d    = ERR;
          end else if (count < CW'(MAX_WORDS)) begin
            mem_wd_d = enc_word;
            state_d  = WRITE;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_OVFL;
            state_d    = ERR;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          mem_addr_d = mem_addr + 32'd4;
          count_d    = count + CW'(1);
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == RUN);
    mem_we_d   = (state_d == WRITE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'h0;
      mem_wd   <= 32'h0;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_wd   <= mem_wd_d;
      count    <= count_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= err_code_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized sessions checked
// against a transaction-level model. Two instances (MAX_WORDS=64 and 2) share
// stimulus; sel chooses which one is observed.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n, start, in_valid, mem_ack;
  logic [31:0] base_addr;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        rdy0, we0, done0, err0, rdy1, we1, done1, err1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  code0, code1;

  logic        in_ready, mem_we, done, err;
  logic [31:0] mem_addr, mem_wd;
  logic [15:0] count;
  logic [1:0]  err_code;
  logic        sel;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_addr;
  int unsigned exp_cnt;
  int unsigned cur_max;
  bit          active;

  always #5 clk = ~clk;

  instr_encoder u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(rdy0), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_we(we0), .mem_addr(addr0),
    .mem_wd(wd0), .mem_ack(mem_ack), .count(cnt0), .done(done0), .err(err0),
    .err_code(code0)
  );

  instr_encoder #(.MAX_WORDS(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(rdy1), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_we(we1), .mem_addr(addr1),
    .mem_wd(wd1), .mem_ack(mem_ack), .count(cnt1), .done(done1), .err(err1),
    .err_code(code1)
  );

  // Observed-instance select.
  always_comb begin
    in_ready = sel ? rdy1  : rdy0;
    mem_we   = sel ? we1   : we0;
    mem_addr = sel ? addr1 : addr0;
    mem_wd   = sel ? wd1   : wd0;
    count    = sel ? cnt1  : cnt0;
    done     = sel ? done1 : done0;
    err      = sel ? err1  : err0;
    err_code = sel ? code1 : code0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding from the opcode table, built arithmetically.
  function automatic logic [31:0] model_word(input int unsigned k, rs, rt, rd, sh, fn, imm, tgt);
    int unsigned ri;
    ri = rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
    case (k)
      0: return rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + sh * 32'h40 + fn;
      1: return 35 * 32'h400_0000 + ri;
      2: return 43 * 32'h400_0000 + ri;
      3: return 4 * 32'h400_0000 + ri;
      4: return 8 * 32'h400_0000 + ri;
      5: return 2 * 32'h400_0000 + tgt;
      default: return 5 * 32'h400_0000 + ri;
    endcase
  endfunction

  function automatic bit model_legal(input int unsigned k);
`ifdef INSTR_ENC_BNE_EN
    return k <= 6;
`else
    return k <= 5;
`endif
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd", mem_wd, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    active = 0;
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    exp_addr = base & ~32'd3;
    exp_cnt = 0;
    active = 1;
    chk("start_ready", in_ready, 1);
    chk("start_addr", mem_addr, exp_addr);
    chk("start_count", count, 0);
    chk("start_err", err, 0);
    chk("start_code", err_code, 0);
  endtask

  task automatic send(input int unsigned k, rs, rt, rd, sh, fn, imm, tgt,
                      input int dly, input logic [31:0] lit);
    logic [31:0] w;
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", in_ready, 1);
      active = 0;
      return;
    end
    in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (k == 7) begin
      chk("end_done", done, 1);
      chk("end_ready", in_ready, 0);
      chk("end_we", mem_we, 0);
      @(negedge clk);
      chk("end_done_pulse", done, 0);
      chk("end_idle_ready", in_ready, 0);
      active = 0;
    end else if (!model_legal(k)) begin
      chk("ill_err", err, 1);
      chk("ill_code", err_code, 1);
      chk("ill_we", mem_we, 0);
      chk("ill_ready", in_ready, 0);
      active = 0;
    end else if (exp_cnt >= cur_max) begin
      chk("ovf_err", err, 1);
      chk("ovf_code", err_code, 2);
      chk("ovf_we", mem_we, 0);
      chk("ovf_ready", in_ready, 0);
      active = 0;
    end else begin
      w = model_word(k, rs % 32, rt % 32, rd % 32, sh % 32, fn % 64, imm % 65536, tgt % 32'h400_0000);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, exp_addr);
      chk("wr_wd", mem_wd, w);
      chk("wr_ready", in_ready, 0);
      if (lit != 32'h0) chk("wr_literal", mem_wd, lit);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk("hold_we", mem_we, 1);
        chk("hold_addr", mem_addr, exp_addr);
        chk("hold_wd", mem_wd, w);
        chk("hold_ready", in_ready, 0);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      exp_cnt++;
      exp_addr = exp_addr + 32'd4;
      chk("ack_we", mem_we, 0);
      chk("ack_count", count, exp_cnt);
      chk("ack_addr", mem_addr, exp_addr);
      chk("ack_ready", in_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned r, k;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    base_addr = '0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0;
    sel = 1'b0; cur_max = 64; active = 0;
    @(negedge clk);
    do_reset();

    // First session: ADDI at a misaligned base.
    do_start(32'h0000_0103);
    send(4, 0, 2, 0, 0, 0, 5, 0, 0, 32'h2002_0005);
    send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Delayed acks with stability checks.
    do_start(32'h0000_0100);
    send(0, 4, 5, 6, 0, 32'h20, 0, 0, 3, 32'h0085_3020);
    send(1, 0, 2, 0, 0, 0, 32'h50, 0, 3, 32'h8C02_0050);
    send(5, 0, 0, 0, 0, 0, 0, 32'h11, 3, 32'h0800_0011);
    send(2, 0, 7, 0, 0, 0, 32'h54, 0, 1, 32'hAC07_0054);
    send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Kind 110.
    do_start(32'h0000_0200);
`ifdef INSTR_ENC_BNE_EN
    send(6, 1, 2, 0, 0, 0, 3, 0, 0, 32'h1422_0003);
    send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    send(6, 1, 2, 0, 0, 0, 3, 0, 0, 0);
`endif

    // Address wrap at the top of memory.
    do_start(32'hFFFF_FFFC);
    send(4, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("wrap_addr", mem_addr, 0);
    send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Overflow on the MAX_WORDS=2 instance.
    do_reset();
    sel = 1'b1; cur_max = 2;
    do_start(32'h0000_0040);
    send(4, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    send(4, 0, 2, 0, 0, 0, 2, 0, 1, 0);
    send(4, 0, 3, 0, 0, 0, 3, 0, 0, 0);
    @(negedge clk);
    chk("ovf_hold_err", err, 1);
    chk("ovf_hold_code", err_code, 2);
    chk("ovf_hold_we", mem_we, 0);
    do_start(32'h0000_0080);
    send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    sel = 1'b0; cur_max = 64;

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      do_start((s == 2) ? 32'hFFFF_FFF8 : $urandom);
      for (int j = 0; j < 12 && active; j++) begin
        r = $urandom_range(15);
        k = (r < 12) ? r % 6 : (r < 14) ? 6 : 7;
        send(k, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(3)), 0);
      end
      if (active) send(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Asynchronous reset during a pending write.
    do_start(32'h0000_0300);
    in_kind = 3'd4; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_we_before", mem_we, 1);
    #2;
    do_reset();
    chk("post_rst_ready", in_ready, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_idle", in_ready, 0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streams symbolic instructions into instruction memory for the single-cycle MIPS core, for boot/self-test program load.
- Accepts one instruction per valid/ready handshake as a kind code plus fields.
- Packs each instruction into a 32-bit MIPS word using the same opcode map the control decoder expects.
- Writes words to consecutive word addresses through a write/acknowledge memory port.

Parameters:
- MAX_WORDS, 64, maximum words written per load session; range 1..65535.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session. Honoured in IDLE and ERR only.
- base_addr  in  32  byte address of first word; sampled on start; bits[1:0] ignored (forced 0).
- in_valid  in  1  instruction offered.
- in_ready  out  1  encoder accepts the instruction this cycle.
- in_kind  in  3  000 RTYPE, 001 LW, 010 SW, 011 BEQ, 100 ADDI, 101 J, 110 BNE (optional), 111 END.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- mem_we  out  1  write request.
- mem_addr  out  32  write byte address.
- mem_wd  out  32  write data.
- mem_ack  in  1  memory accepts the write this cycle.
- count  out  16  words written this session.
- done  out  1  one-cycle pulse when END is accepted.
- err  out  1  sticky error flag; cleared by start or reset.
- err_code  out  2  00 none, 01 illegal kind, 10 overflow.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wd=0.
  - count=0, done=0, err=0, err_code=00.
- States: IDLE, RUN, WRITE, ERR.
- IDLE:
  - in_ready=0.
  - On start: mem_addr = {base_addr[31:2],2'b00}, count=0, err=0, err_code=00; next state RUN.
- RUN:
  - in_ready=1. A handshake occurs when in_valid=1 in a cycle with in_ready=1.
  - Legal kind 000–101 with count<MAX_WORDS: latch encoded word into mem_wd; next state WRITE.
  - Encoding:
    - RTYPE = {6'b000000, rs, rt, rd, shamt, funct}
    - LW = {100011, rs, rt, imm}
    - SW = {101011, rs, rt, imm}
    - BEQ = {000100, rs, rt, imm}
    - ADDI = {001000, rs, rt, imm}
    - J = {000010, target}
  - Legal kind with count==MAX_WORDS: err=1, err_code=10, no write; next state ERR.
  - Illegal kind: err=1, err_code=01; next state ERR.
  - END: done=1 for exactly the following cycle, no write; next state IDLE.
  - start in RUN is ignored.
- WRITE:
  - in_ready=0; mem_we=1; mem_addr and mem_wd held stable until ack.
  - On mem_ack=1: mem_addr += 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), count += 1; next state RUN.
  - mem_we deasserts the cycle after ack.
  - Latency: handshake in cycle N -> mem_we=1 in cycle N+1. With ack in N+1, the next handshake is possible in N+2.
  - Maximum throughput: one word per 2 cycles.
  - start in WRITE is ignored.
- ERR:
  - in_ready=0, mem_we=0; err and err_code held.
  - start restarts the session exactly as from IDLE.
- Async reset mid-write: mem_we drops immediately; the partial session is abandoned.
- Field bits unused by a kind are ignored.

Optional Feature:
- Macro: INSTR_ENC_BNE_EN.
- Defined: kind 110 is legal and encodes BNE = {000101, rs, rt, imm}.
- Undefined: kind 110 is illegal (err_code=01).

Test Plan:
- Reset then start, base_addr=0x00000103; send ADDI rs=0 rt=2 imm=5 with ack immediate
  -> mem_addr=0x00000100, mem_wd=0x20020005, then count=1.
- Send RTYPE rs=4 rt=5 rd=6 shamt=0 funct=0x20, then LW rs=0 rt=2 imm=0x50, then J target=0x11, with ack delayed 3 cycles each
  -> words 0x00853020 @0x100, 0x8C020050 @0x104, 0x08000011 @0x108.
  -> mem_we/addr/data stable across the wait; in_ready=0 during WRITE.
- SW rs=0 rt=7 imm=0x54 then END
  -> word 0xAC070054 written, then done pulses once, state IDLE, in_ready=0.
- MAX_WORDS=2; send 3 legal instructions
  -> 2 writes; third sets err=1, err_code=10; no mem_we.
  -> start clears err and resets count to 0.
- Kind 110 -> with macro: BEQ/BNE-style word 0x14220003 for rs=1 rt=2 imm=3; without macro: err_code=01.
- Assert reset_n=0 while mem_we=1
  -> mem_we=0 asynchronously, all outputs at reset values; start required to resume.
